// File: rtl/result_bcd_converter.sv
// Sequential shift-add-3 binary-to-BCD converter feeding the per-digit 7-segment decoders.
// Produces BCD digits plus sign, leading-zero blank mask and overflow, all updated together on completion.
module result_bcd_converter #(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3,
  parameter bit SIGNED   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   value_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg,
  output logic [DIGITS-1:0]     blank_mask,
  output logic                  overflow
);

  // Each 3 input bits add less than one decimal digit, so this many digits always hold the full magnitude.
  localparam int MIN_DIGITS = (IN_WIDTH + 2) / 3;
  localparam int SCR_DIGITS = (DIGITS > MIN_DIGITS) ? DIGITS : MIN_DIGITS;
  localparam int SCR_W      = 4 * SCR_DIGITS;
  localparam int CNT_W      = $clog2(IN_WIDTH + 1);
  localparam logic [DIGITS-1:0] BLANK_RESET = {DIGITS{1'b1}} << 1;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} stateT;

  stateT               state;
  logic [SCR_W-1:0]    scratch;
  logic [SCR_W-1:0]    scratchAdj;
  logic [IN_WIDTH-1:0] magnitude;
  logic [IN_WIDTH-1:0] magIn;
  logic [CNT_W-1:0]    count;
  logic                negPend;
  logic                isOverflow;
  logic                upperZero;
  logic [DIGITS-1:0]   blankNext;

  always_comb begin
    magIn = (SIGNED && value_in[IN_WIDTH-1]) ? -value_in : value_in;
  end

  always_comb begin
    scratchAdj = scratch;
    for (int d = 0; d < SCR_DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) begin
        scratchAdj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
    end
  end

  // Guard digits above the displayed ones are nonzero exactly when the magnitude does not fit.
  if (SCR_DIGITS > DIGITS) begin : gOverflow
    assign isOverflow = |scratch[SCR_W-1:4*DIGITS];
  end else begin : gNoOverflow
    assign isOverflow = 1'b0;
  end

  always_comb begin
    blankNext = '0;
    upperZero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upperZero    = upperZero && (scratch[4*k +: 4] == 4'd0);
      blankNext[k] = upperZero;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd_out    <= '0;
      neg        <= 1'b0;
      overflow   <= 1'b0;
      blank_mask <= BLANK_RESET;
      scratch    <= '0;
      magnitude  <= '0;
      count      <= '0;
      negPend    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            magnitude <= magIn;
            negPend   <= SIGNED && value_in[IN_WIDTH-1];
            scratch   <= '0;
            count     <= CNT_W'(IN_WIDTH);
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch, magnitude} <= {scratchAdj, magnitude} << 1;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          bcd_out    <= isOverflow ? {DIGITS{4'h9}} : scratch[4*DIGITS-1:0];
          blank_mask <= isOverflow ? '0 : blankNext;
          overflow   <= isOverflow;
          neg        <= negPend;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
